// File: rtl/signed_sum_accumulator_if.sv
// Stream bus between the adder datapath and the frame accumulator.
// The master drives samples and consumes results. The slave is the accumulator.
interface signed_sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/signed_sum_accumulator.sv
// Saturating signed frame accumulator with valid/ready handshakes.
// It sums N signed samples into a clamped ACC_W-bit total, presents the
// total with a sticky saturation flag, and restarts once the result is taken.
module signed_sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 7,
    parameter int N     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    signed_sum_accumulator_if.slave bus
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // One guard bit is enough: |acc| <= 2^(ACC_W-1) and |in| <= 2^(IN_W-1) <= 2^(ACC_W-1).
    logic [ACC_W:0]   in_ext;
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] sum_clamped;

    // Widen, add, and clamp the sample into the running total.
    always_comb begin
        in_ext  = {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        acc_ext = {acc_q[ACC_W-1], acc_q};
        sum     = in_ext + acc_ext;
        // The top two bits differ only when the result leaves the ACC_W range.
        // The guard bit then gives the direction of the clamp.
        ovf     = sum[ACC_W] ^ sum[ACC_W-1];
        if (!ovf)
            sum_clamped = sum[ACC_W-1:0];
        else if (sum[ACC_W])
            sum_clamped = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sum_clamped = {1'b0, {(ACC_W-1){1'b1}}};
    end

    // Next state: clear wins over both handshakes.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc_d = sum_clamped;
                        sat_d = sat_q | ovf;
                        if (cnt_q == CNT_W'(N-1)) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    // State register. Reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = acc_q;
    assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Bench for signed_sum_accumulator: directed frames from the test plan plus
// randomized traffic. Results are checked against an integer model of the frame sum.
module tb_signed_sum_accumulator;
    localparam int IN_W  = 5;
    localparam int ACC_W = 7;
    localparam int N     = 8;
    localparam int AMAX  = 63;
    localparam int AMIN  = -64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    // Behavioural model: frame sum as a plain integer with clamping.
    int m_acc  = 0;
    bit m_sat  = 0;
    int m_cnt  = 0;
    bit m_hold = 0;

    signed_sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    signed_sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int out_val();
        return int'($signed(bus.out_data));
    endfunction

    task automatic put(input bit v, input int d);
        bus.in_valid = v;
        bus.in_data  = d[IN_W-1:0];
    endtask

    task automatic model_reset();
        m_acc = 0; m_sat = 0; m_cnt = 0; m_hold = 0;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        int s;
        if (clear) begin
            model_reset();
        end else if (!m_hold) begin
            if (bus.in_valid) begin
                s = m_acc + int'($signed(bus.in_data));
                if (s > AMAX) begin s = AMAX; m_sat = 1; end
                else if (s < AMIN) begin s = AMIN; m_sat = 1; end
                m_acc = s;
                m_cnt++;
                if (m_cnt == N) begin m_cnt = 0; m_hold = 1; end
            end
        end else if (bus.out_ready) begin
            m_acc = 0; m_sat = 0; m_hold = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int vals[8]);
        for (int i = 0; i < N; i++) begin
            put(1, vals[i]);
            tick();
        end
        put(0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; clear = 0; put(0, 0); bus.out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_run++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_val()); end
        n_run++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got %b want 0", bus.out_sat); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int v[8] = '{5, -3, 9, -12, 1, 0, 7, -6};
        bus.out_ready = 1;
        send_frame(v);
        n_run++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL nominal_out_valid got %b want 1", bus.out_valid); end
        n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL nominal_in_ready got %b want 0", bus.in_ready); end
        n_run++; if (out_val() != 1 || out_val() != m_acc) begin n_fail++; $display("FAIL nominal_out_data got %0d want 1", out_val()); end
        n_run++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL nominal_out_sat got %b want 0", bus.out_sat); end
        tick();
        n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_one_cycle got %b want 0", bus.out_valid); end
        n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL nominal_in_ready_back got %b want 1", bus.in_ready); end
    endtask

    task automatic test_saturation();
        int pos[8] = '{15, 15, 15, 15, 15, 15, 15, 15};
        int neg[8] = '{-16, -16, -16, -16, -16, -16, -16, -16};
        int mix[8] = '{15, 15, 15, 15, 15, -16, -16, -16};
        int want[3] = '{63, -64, 15};
        bus.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) send_frame(pos);
            else if (k == 1) send_frame(neg);
            else send_frame(mix);
            n_run++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat%0d_out_valid got %b want 1", k, bus.out_valid); end
            n_run++; if (out_val() != want[k] || out_val() != m_acc) begin n_fail++; $display("FAIL sat%0d_out_data got %0d want %0d", k, out_val(), want[k]); end
            n_run++; if (bus.out_sat !== 1'b1) begin n_fail++; $display("FAIL sat%0d_out_sat got %b want 1", k, bus.out_sat); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int v[8] = '{5, -3, 9, -12, 1, 0, 7, -6};
        int f[8] = '{4, 4, 4, 4, 4, 4, 4, 4};
        bus.out_ready = 0;
        send_frame(v);
        put(1, 4);
        for (int i = 0; i < 5; i++) begin
            n_run++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d got rdy=%b vld=%b want 0/1", i, bus.in_ready, bus.out_valid); end
            n_run++; if (out_val() != 1) begin n_fail++; $display("FAIL bp_data%0d got %0d want 1", i, out_val()); end
            tick();
        end
        bus.out_ready = 1;
        tick();
        n_run++; if (bus.in_ready !== 1'b1 || out_val() != 0) begin n_fail++; $display("FAIL bp_release got rdy=%b data=%0d want 1/0", bus.in_ready, out_val()); end
        send_frame(f);
        n_run++; if (bus.out_valid !== 1'b1 || out_val() != 32 || out_val() != m_acc) begin n_fail++; $display("FAIL bp_next_frame got vld=%b data=%0d want 1/32", bus.out_valid, out_val()); end
        tick();
    endtask

    task automatic test_gaps();
        int cycles = 0;
        bus.out_ready = 1;
        for (int i = 0; i < N; i++) begin
            put(1, 2); tick(); cycles++;
            if (i != N - 1) begin
                put(0, 9); tick(); cycles++;
                n_run++; if (bus.out_valid !== 1'b0 || out_val() != 2 * (i + 1)) begin n_fail++; $display("FAIL gap_partial%0d got vld=%b data=%0d want 0/%0d", i, bus.out_valid, out_val(), 2 * (i + 1)); end
            end
        end
        put(0, 0);
        n_run++; if (bus.out_valid !== 1'b1 || out_val() != 16 || cycles != 15) begin n_fail++; $display("FAIL gap_total got vld=%b data=%0d cyc=%0d want 1/16/15", bus.out_valid, out_val(), cycles); end
        tick();
    endtask

    task automatic test_clear();
        int ones[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
        bus.out_ready = 1;
        for (int i = 0; i < 3; i++) begin put(1, 10); tick(); end
        clear = 1; tick(); clear = 0;
        n_run++; if (out_val() != 0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_mid got data=%0d rdy=%b want 0/1", out_val(), bus.in_ready); end
        send_frame(ones);
        n_run++; if (bus.out_valid !== 1'b1 || out_val() != 8 || bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL clear_frame got vld=%b data=%0d sat=%b want 1/8/0", bus.out_valid, out_val(), bus.out_sat); end
        tick();
        bus.out_ready = 0;
        send_frame(ones);
        n_run++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_hold_pre got %b want 1", bus.out_valid); end
        clear = 1; tick(); clear = 0;
        n_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || out_val() != 0) begin n_fail++; $display("FAIL clear_hold got vld=%b rdy=%b data=%0d want 0/1/0", bus.out_valid, bus.in_ready, out_val()); end
        bus.out_ready = 1;
    endtask

    task automatic test_async_reset();
        int m1[8] = '{-1, -1, -1, -1, -1, -1, -1, -1};
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin put(1, 20); tick(); end
        put(0, 0);
        #2 rst_n = 0;
        #1;
        n_run++; if (bus.out_data !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL async_reset got data=%0d rdy=%b vld=%b sat=%b want 0/1/0/0", out_val(), bus.in_ready, bus.out_valid, bus.out_sat); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        send_frame(m1);
        n_run++; if (bus.out_valid !== 1'b1 || out_val() != -8 || bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL async_after got vld=%b data=%0d sat=%b want 1/-8/0", bus.out_valid, out_val(), bus.out_sat); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            put($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 99) == 0);
            tick();
            n_run++;
            if (bus.out_valid !== m_hold || bus.in_ready !== !m_hold || out_val() != m_acc || bus.out_sat !== m_sat) begin
                n_fail++;
                $display("FAIL rand_c%0d got vld=%b rdy=%b data=%0d sat=%b want %b/%b/%0d/%b",
                         c, bus.out_valid, bus.in_ready, out_val(), bus.out_sat, m_hold, !m_hold, m_acc, m_sat);
            end
        end
        clear = 0; put(0, 0);
    endtask

    initial begin
        put(0, 0);
        bus.out_ready = 0;
        test_reset();
        test_nominal();
        test_saturation();
        test_backpressure();
        test_gaps();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
